// File: rtl/fdivsqrt_sched_pkg.sv
// Shared definitions for the divide/square-root scheduler.
//   DIVSQRT_TAGW : destination-tag width, shared with the MDU/FPU scoreboard
//   schedState_t : scheduler FSM state encoding
package fdivsqrt_sched_pkg;

    localparam int DIVSQRT_TAGW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } schedState_t;

endpackage

// File: rtl/fdivsqrt_cyclecnt.sv
// Iteration-cycle down-counter for the divide/square-root scheduler.
//   clk, reset_n : clock, asynchronous active-low clear
//   load/loadVal : load a new iteration count
//   dec          : decrement by one
//   clear        : synchronous clear (abort)
//   last         : count == 1, i.e. the final iteration cycle
module fdivsqrt_cyclecnt #(
    parameter int DURLEN = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DURLEN-1:0] loadVal,
    input  logic              dec,
    input  logic              clear,
    output logic              last
);

    localparam logic [DURLEN-1:0] ONE = DURLEN'(1);

    logic [DURLEN-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec) begin
            count <= count - ONE;
        end
    end

    assign last = (count == ONE);

endmodule

// File: rtl/fdivsqrt_sched.sv
// Arbiter and sequencer for the shared divide/square-root unit.
//   fp_req_i/fp_tag_i/fp_gnt_o    : FP pipe request, tag, grant
//   int_req_i/int_tag_i/int_gnt_o : integer MDU request, tag, grant
//   intsel_o, start_o             : operand select and load strobe (grant cycle)
//   cycles_i, special_i           : iteration count / special case (grant cycle)
//   step_o                        : recurrence iteration enable
//   flush_i                       : abort any operation
//   busy_o                        : unit occupied
//   done_o/done_int_o/done_tag_o  : result valid, owner, tag
//   res_ready_i                   : consumer accepts the result
module fdivsqrt_sched
    import fdivsqrt_sched_pkg::*;
#(
    parameter int DURLEN = 6,
    parameter int TAGW   = DIVSQRT_TAGW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fp_req_i,
    input  logic [TAGW-1:0]   fp_tag_i,
    output logic              fp_gnt_o,
    input  logic              int_req_i,
    input  logic [TAGW-1:0]   int_tag_i,
    output logic              int_gnt_o,
    output logic              intsel_o,
    input  logic [DURLEN-1:0] cycles_i,
    input  logic              special_i,
    output logic              start_o,
    output logic              step_o,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              done_int_o,
    output logic [TAGW-1:0]   done_tag_o,
    input  logic              res_ready_i
);

    schedState_t     state, nextState;
    logic            lastInt;
    logic            ownerQ;
    logic [TAGW-1:0] tagQ;
    logic            fpPick, intPick, canGrant;
    logic            cntLoad, cntDec, cntClear, cntLast;

    // Round-robin on ties: the side that did not win last time goes first.
    assign fpPick  = fp_req_i  & (~int_req_i | lastInt);
    assign intPick = int_req_i & (~fp_req_i  | ~lastInt);
    // Grants are combinational, so they are also masked while reset is held
    // to keep every output low during reset.
    assign canGrant = (state == IDLE) & reset_n & ~flush_i;

    always_comb begin
        nextState = state;
        fp_gnt_o  = 1'b0;
        int_gnt_o = 1'b0;
        intsel_o  = 1'b0;
        start_o   = 1'b0;
        step_o    = 1'b0;
        done_o    = 1'b0;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        cntClear  = 1'b0;
        case (state)
            IDLE: begin
                if (canGrant && (fpPick || intPick)) begin
                    fp_gnt_o  = fpPick;
                    int_gnt_o = intPick;
                    intsel_o  = intPick;
                    start_o   = 1'b1;
                    cntLoad   = 1'b1;
                    nextState = (special_i || cycles_i == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                step_o = 1'b1;
                if (flush_i) begin
                    cntClear  = 1'b1;
                    nextState = IDLE;
                end else begin
                    cntDec = 1'b1;
                    if (cntLast) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                if (flush_i) begin
                    cntClear  = 1'b1;
                    nextState = IDLE;
                end else begin
                    done_o = 1'b1;
                    if (res_ready_i) begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            lastInt <= 1'b1;
            ownerQ  <= 1'b0;
            tagQ    <= '0;
        end else begin
            state <= nextState;
            if (start_o) begin
                lastInt <= intsel_o;
                ownerQ  <= intsel_o;
                tagQ    <= intsel_o ? int_tag_i : fp_tag_i;
            end
        end
    end

    fdivsqrt_cyclecnt #(
        .DURLEN(DURLEN)
    ) uCycleCnt (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (cntLoad),
        .loadVal(cycles_i),
        .dec    (cntDec),
        .clear  (cntClear),
        .last   (cntLast)
    );

    assign busy_o     = (state != IDLE);
    assign done_int_o = done_o & ownerQ;
    assign done_tag_o = done_o ? tagQ : '0;

endmodule

// File: tb/tb_fdivsqrt_sched.sv
module tb_fdivsqrt_sched;

    localparam int DURLEN = 6;
    localparam int TAGW   = 5;

    logic              clk;
    logic              reset_n;
    logic              fp_req_i;
    logic [TAGW-1:0]   fp_tag_i;
    logic              fp_gnt_o;
    logic              int_req_i;
    logic [TAGW-1:0]   int_tag_i;
    logic              int_gnt_o;
    logic              intsel_o;
    logic [DURLEN-1:0] cycles_i;
    logic              special_i;
    logic              start_o;
    logic              step_o;
    logic              flush_i;
    logic              busy_o;
    logic              done_o;
    logic              done_int_o;
    logic [TAGW-1:0]   done_tag_o;
    logic              res_ready_i;

    fdivsqrt_sched #(
        .DURLEN(DURLEN),
        .TAGW  (TAGW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fp_req_i   (fp_req_i),
        .fp_tag_i   (fp_tag_i),
        .fp_gnt_o   (fp_gnt_o),
        .int_req_i  (int_req_i),
        .int_tag_i  (int_tag_i),
        .int_gnt_o  (int_gnt_o),
        .intsel_o   (intsel_o),
        .cycles_i   (cycles_i),
        .special_i  (special_i),
        .start_o    (start_o),
        .step_o     (step_o),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .done_int_o (done_int_o),
        .done_tag_o (done_tag_o),
        .res_ready_i(res_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              owner;
        logic [TAGW-1:0] tag;
        int              steps;
        int              lat;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    // Reference arbitration state: true when the last grant went to integer.
    bit   lastIntM = 1'b1;
    bit   fpPend = 1'b0;
    bit   intPend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] allOuts();
        return {fp_gnt_o, int_gnt_o, intsel_o, start_o, step_o, busy_o,
                done_o, done_int_o, done_tag_o};
    endfunction

    // Monitor: counts step pulses and latency of each operation and compares
    // every presented result against the scoreboard queue.
    int              cyc = 0;
    int              startCyc = 0;
    int              stepCnt = 0;
    bit              prevDone = 1'b0;
    bit              heldOwner;
    logic [TAGW-1:0] heldTag;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prevDone = 1'b0;
        end else begin
            if (fp_gnt_o && int_gnt_o) begin
                errors++;
                checks++;
                $display("FAIL both_gnt: got 1 1 expected one grant at most (t=%0t)", $time);
            end
            if (fp_gnt_o || int_gnt_o || start_o) begin
                check("start_eq_gnt", start_o, fp_gnt_o | int_gnt_o);
                check("gnt_while_busy", busy_o, 0);
            end
            if (start_o) begin
                startCyc = cyc;
                stepCnt  = 0;
            end
            if (step_o) stepCnt++;
            if (done_o && !prevDone) begin
                if (expQ.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_done: got done tag %0h expected no result (t=%0t)",
                             done_tag_o, $time);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("done_owner", done_int_o, e.owner);
                    check("done_tag", done_tag_o, e.tag);
                    check("step_count", stepCnt, e.steps);
                    check("done_latency", cyc - startCyc, e.lat);
                end
                heldOwner = done_int_o;
                heldTag   = done_tag_o;
            end else if (done_o) begin
                check("held_owner", done_int_o, heldOwner);
                check("held_tag", done_tag_o, heldTag);
            end
            prevDone = done_o;
        end
    end

    // Issues one operation starting in an IDLE cycle (called at posedge+1).
    // flushMode: 0 none, 1 flush at ITER cycle fAt, 2 flush with ready in DONE.
    task automatic runOp(input bit fpNew, input logic [TAGW-1:0] fpT,
                         input bit intNew, input logic [TAGW-1:0] intT,
                         input int nCyc, input bit sp, input int rdy,
                         input int flushMode, input int fAt);
        bit              winInt;
        bit              gotGnt;
        bit              instant;
        bit              seen;
        int              fm;
        exp_t            e;
        if (fpNew) begin fpPend = 1'b1; fp_req_i = 1'b1; fp_tag_i = fpT; end
        if (intNew) begin intPend = 1'b1; int_req_i = 1'b1; int_tag_i = intT; end
        cycles_i  = DURLEN'(nCyc);
        special_i = sp;
        winInt = (fpPend && intPend) ? !lastIntM : intPend;
        lastIntM = winInt;
        instant = sp || (nCyc == 0);
        fm = flushMode;
        if (fm == 1 && (instant || nCyc < 2)) fm = 0;
        @(negedge clk);
        gotGnt = winInt ? int_gnt_o : fp_gnt_o;
        check("grant", gotGnt, 1);
        check("grant_other", winInt ? fp_gnt_o : int_gnt_o, 0);
        check("intsel", intsel_o, winInt);
        e.owner = winInt;
        e.tag   = winInt ? int_tag_i : fp_tag_i;
        e.steps = instant ? 0 : nCyc;
        e.lat   = e.steps + 1;
        if (fm != 1) expQ.push_back(e);
        @(posedge clk); #1;
        if (winInt) begin int_req_i = 1'b0; intPend = 1'b0; end
        else begin fp_req_i = 1'b0; fpPend = 1'b0; end
        if (fm == 1) begin
            repeat (fAt - 1) begin @(posedge clk); #1; end
            flush_i = 1'b1;
            @(negedge clk);
            check("flush_iter_done", done_o, 0);
            @(posedge clk); #1;
            flush_i = 1'b0;
            check("flush_iter_idle", busy_o, 0);
        end else begin
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done_o) begin seen = 1'b1; break; end
                @(posedge clk); #1;
            end
            check("done_seen", seen, 1);
            for (int r = 0; r < rdy; r++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("done_held", done_o, 1);
            end
            @(posedge clk); #1;
            res_ready_i = 1'b1;
            flush_i     = (fm == 2);
            if (fm == 2) begin
                @(negedge clk);
                check("flush_done_low", done_o, 0);
            end
            @(posedge clk); #1;
            res_ready_i = 1'b0;
            flush_i     = 1'b0;
            check("back_to_idle", busy_o, 0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        fp_req_i    = 1'b0;
        fp_tag_i    = '0;
        int_req_i   = 1'b0;
        int_tag_i   = '0;
        cycles_i    = '0;
        special_i   = 1'b0;
        flush_i     = 1'b0;
        res_ready_i = 1'b0;
        #3;
        check("reset_outs", allOuts(), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Tie from reset goes to FP, then the pending integer, then FP on a tie.
        runOp(1, 5'd1, 1, 5'd2, 3, 0, 0, 0, 0);
        runOp(0, 5'd0, 0, 5'd0, 3, 0, 0, 0, 0);
        runOp(1, 5'd4, 1, 5'd6, 3, 0, 0, 0, 0);
        runOp(0, 5'd0, 0, 5'd0, 2, 0, 0, 0, 0);
        // Integer special case (divide by zero).
        runOp(0, 5'd0, 1, 5'd3, 9, 1, 0, 0, 0);
        // Result held for 5 cycles with the other requester pending.
        runOp(1, 5'd9, 1, 5'd10, 4, 0, 5, 0, 0);
        runOp(0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
        // FP only, 14 iterations.
        runOp(1, 5'd7, 0, 5'd0, 14, 0, 0, 0, 0);
        // Flush at the 4th ITER cycle, pending request granted right after.
        runOp(1, 5'd11, 1, 5'd12, 10, 0, 0, 1, 4);
        runOp(0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            bit fpNew, intNew;
            int n, fm, fAt;
            fpNew  = !fpPend && ($urandom % 3 != 0);
            intNew = !intPend && ($urandom % 3 != 0);
            if (!fpPend && !intPend && !fpNew && !intNew) fpNew = 1'b1;
            n  = $urandom % 16;
            fm = $urandom % 10;
            fm = (fm == 0) ? 1 : (fm == 1) ? 2 : 0;
            fAt = (n >= 2) ? 1 + ($urandom % (n - 1)) : 1;
            runOp(fpNew, 5'($urandom), intNew, 5'($urandom), n,
                  ($urandom % 8 == 0), $urandom % 4, fm, fAt);
        end

        // Asynchronous reset in the middle of an iteration.
        if (!fpPend) begin fp_req_i = 1'b1; fp_tag_i = 5'd21; fpPend = 1'b1; end
        if (!intPend) begin int_req_i = 1'b1; int_tag_i = 5'd22; intPend = 1'b1; end
        cycles_i  = DURLEN'(10);
        special_i = 1'b0;
        @(negedge clk);
        check("pre_reset_grant", fp_gnt_o | int_gnt_o, 1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_outs", allOuts(), 0);
        expQ.delete();
        lastIntM = 1'b1;
        #20;
        fp_req_i  = 1'b0;
        int_req_i = 1'b0;
        fpPend    = 1'b0;
        intPend   = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        runOp(1, 5'd13, 1, 5'd14, 5, 0, 1, 0, 0);
        runOp(0, 5'd0, 0, 5'd0, 2, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
